dis7seg_scan_driver: RTL and testbench
======================================

// Module: dis7seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for N_DIGITS common-anode/cathode 7-segment digits.
//  Latches per-digit 4-bit codes, decimal points and a blink mask on a load strobe.
//  Decodes codes to hex glyphs 0-F and scans one digit per slot.
//  Supersedes the fixed 2-input speed decoder. The FSM loads speed/state codes;
//  the block drives the board display pins directly.
// PARAMETERS
//  N_DIGITS      4      digits scanned, legal range 1..8
//  CLK_DIV       50000  clock cycles per digit slot (>=2)
//  BLINK_FRAMES  64     full scan frames per blink half-period (>=1)
//  ACTIVE_LOW    1      1: seg/dp/an active-low pins; 0: active-high
// PORTS
//  clk         in   1           system clock, all logic rising-edge
//  rst         in   1           synchronous reset, active-high
//  load        in   1           1-cycle strobe: capture codes/dp_in/blink_mask
//  codes       in   4*N_DIGITS  digit i code at codes[4i+3:4i]
//  dp_in       in   N_DIGITS    decimal point per digit
//  blink_mask  in   N_DIGITS    1 = digit blanks during blink-off phase
//  enable      in   1           0 = display fully blanked
//  seg         out  7           segments, seg[0]=a .. seg[6]=g
//  dp          out  1           decimal point of the active digit
//  an          out  N_DIGITS    digit select, one-hot active
//  frame_done  out  1           1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  Reset (sync, high): zero the shadow regs (codes, dp, blink).
//   Zero prescaler, digit index, frame counter and blink phase.
//   seg, dp, an = inactive level (all 1 if ACTIVE_LOW, else 0); frame_done=0.
//   Reset mid-scan aborts at once; no partial frame_done.
//  Prescaler: counts 0..CLK_DIV-1.
//   At CLK_DIV-1 it goes to 0 and the index advances; N_DIGITS-1 wraps to 0.
//   The wrap asserts frame_done for exactly that cycle.
//  Frame counter: counts frame_done pulses 0..BLINK_FRAMES-1.
//   On its wrap, blink phase toggles. Phase 0 = visible, 1 = off.
//  Shadow regs: on load=1, capture codes/dp_in/blink_mask at that edge.
//   Held otherwise; no tearing mid-frame.
//  Outputs: all registered, computed from the index and shadow regs of the
//   previous cycle. Latency is 1 clk from index change or load to pin change.
//  After rst falls, digit 0 is active from the first edge, for CLK_DIV cycles.
//   Each later digit is also active for CLK_DIV cycles.
//  Active digit i:
//   an has only bit i active.
//   seg shows the hex glyph of code i:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//    A=77 b=7C C=39 d=5E E=79 F=71
//    (gfedcba, active-high form; inverted when ACTIVE_LOW=1).
//   dp = dp_in[i].
//  Blanking: if enable=0, or (blink phase=1 and blink_mask[i]=1):
//   an, seg and dp all go inactive.
//   Counters keep running, so the scan phase is preserved.
//  load in the same cycle as a digit advance: the new digit uses the new data.
//  N_DIGITS=1: index stays 0; frame_done pulses every CLK_DIV cycles.
// TESTING (sim: N_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
//  1. rst=1 for 3 clk.
//     -> seg=7F, dp=1, an=F, frame_done=0 throughout.
//     Then release, load codes=16'h3210, enable=1.
//     -> an=E,D,B,7 for 4 clk each; seg=40,79,24,30.
//  2. Free run.
//     -> frame_done pulses once every 16 clk, on the an 7->E transition.
//  3. load codes=16'hFEDC, dp_in=4'b0101 mid-digit-1.
//     -> next cycle seg=21 (d, ~5E); dp=1 on digit 1.
//     -> digit 2 shows seg=06, dp=0.
//  4. blink_mask=4'b0010.
//     -> digit 1 shows for 2 frames, then is blank (an=F, seg=7F) for 2 frames.
//     -> digits 0,2,3 are unaffected.
//  5. enable=0 for 10 clk.
//     -> an=F, seg=7F.
//     On re-enable, the scan resumes at the index the counters have reached.
//  6. rst asserted mid-digit-2.
//     -> next edge outputs inactive, shadow=0.
//     After release, digit 0 shows seg=40 ("0").

Source files
------------

// File: rtl/dis7seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadow-latched hex codes, decimal points
// and blink mask, one digit per CLK_DIV-cycle slot, registered pin outputs.
module dis7seg_scan_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   codes,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                DP_OFF  = ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW}};

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_OFF     = 1'b1
  } phase_e;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] codes_q, codes_d;
  logic [N_DIGITS-1:0]   dps_q, dps_d;
  logic [N_DIGITS-1:0]   bmask_q, bmask_d;
  logic                  wrap_q;
  logic                  fd_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blink;
  logic [N_DIGITS-1:0]   an_on;
  logic                  blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] c);
    logic [6:0] g;
    g = 7'h00;
    case (c)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    slot_end = (pre_q == PRE_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);

    pre_d   = slot_end ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_OFF : PH_VISIBLE;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    codes_d = load ? codes      : codes_q;
    dps_d   = load ? dp_in      : dps_q;
    bmask_d = load ? blink_mask : bmask_q;

    // Pins follow the current index and shadow contents, so a load coinciding
    // with a digit advance is seen by the incoming digit.
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    an_on     = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code  = codes_q[4*i +: 4];
        cur_dp    = dps_q[i];
        cur_blink = bmask_q[i];
        an_on[i]  = 1'b1;
      end
    end

    blank = !enable || ((phase_q == PH_OFF) && cur_blink);
    seg_d = (blank ? 7'h00 : hex_glyph(cur_code)) ^ SEG_OFF;
    dp_d  = (!blank && cur_dp) ^ DP_OFF;
    an_d  = (blank ? '0 : an_on) ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= PH_VISIBLE;
      codes_q <= '0;
      dps_q   <= '0;
      bmask_q <= '0;
      wrap_q  <= 1'b0;
      fd_q    <= 1'b0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      codes_q <= codes_d;
      dps_q   <= dps_d;
      bmask_q <= bmask_d;
      // Delayed one extra stage so the pulse coincides with digit 0 reaching the pins.
      wrap_q  <= wrap;
      fd_q    <= wrap_q;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_dis7seg_scan_driver.sv
// Self-checking bench for dis7seg_scan_driver with an arithmetic reference model
// driven by the number of clocks elapsed since reset release.
module tb_dis7seg_scan_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] codes;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        enable;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dis7seg_scan_driver #(
    .N_DIGITS(N),
    .CLK_DIV(DIV),
    .BLINK_FRAMES(BF),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .codes(codes),
    .dp_in(dp_in),
    .blink_mask(blink_mask),
    .enable(enable),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  // Reference model: pins after an edge reflect the scan position reached by
  // the previous edge (m clocks since release) and the shadow data before it.
  logic [6:0]  GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned m;
  int unsigned md;
  logic        mph, mblank;
  logic [3:0]  mc;
  logic [15:0] sh_codes;
  logic [3:0]  sh_dp, sh_bm;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fd;

  always @(posedge clk) begin
    if (rst) begin
      m = 0;
      sh_codes = '0; sh_dp = '0; sh_bm = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
    end else begin
      md     = (m / DIV) % N;
      mph    = ((m / (DIV * N * BF)) % 2) == 1;
      mblank = !enable || (mph && sh_bm[md]);
      mc     = sh_codes[4*md +: 4];
      exp_an  = mblank ? 4'hF : ~(4'b0001 << md);
      exp_seg = mblank ? 7'h7F : ~GLYPH[mc];
      exp_dp  = mblank ? 1'b1 : ~sh_dp[md];
      exp_fd  = (m > 0) && ((m % (DIV * N)) == 0);
      if (load) begin
        sh_codes = codes; sh_dp = dp_in; sh_bm = blink_mask;
      end
      m = m + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; enable = 1'b0;
    codes = '0; dp_in = '0; blink_mask = '0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state: got seg=%h dp=%b an=%h fd=%b, want seg=7f dp=1 an=f fd=0",
                 seg, dp, an, frame_done);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_tbl [4];
    logic [6:0] seg_tbl [4];
    an_tbl  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30};
    rst = 1'b0; load = 1'b1; codes = 16'h3210; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      n_tests++;
      if ({seg, dp, an, frame_done} !== {seg_tbl[i/4], 1'b1, an_tbl[i/4], 1'b0}) begin
        n_fail++;
        $display("FAIL scan_3210 cycle %0d: got seg=%h dp=%b an=%h fd=%b, want seg=%h dp=1 an=%h fd=0",
                 i, seg, dp, an, frame_done, seg_tbl[i/4], an_tbl[i/4]);
      end
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL scan_model cycle %0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                 i, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
  endtask

  task automatic test_frame_done();
    int pulses = 0;
    int last = -1;
    logic [3:0] prev_an = 4'h7;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL frame_model cycle %0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                 i, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
      if (frame_done === 1'b1) begin
        pulses++;
        n_tests++;
        if (an !== 4'hE || prev_an !== 4'h7 || (last >= 0 && (i - last) != 16)) begin
          n_fail++;
          $display("FAIL frame_done_align cycle %0d: got an=%h prev_an=%h gap=%0d, want an=e prev_an=7 gap=16",
                   i, an, prev_an, i - last);
        end
        last = i;
      end
      prev_an = an;
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d pulses, want 4", pulses);
    end
  endtask

  task automatic test_load_mid_digit();
    bit found = 1'b0;
    logic [3:0] prev_an = an;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an === 4'hD && prev_an !== 4'hD) found = 1'b1;
      prev_an = an;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL load_wait_digit1: got an=%h, want an=d within 20 cycles", an);
    end
    load = 1'b1; codes = 16'hFEDC; dp_in = 4'b0101;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({seg, dp, an} !== {7'h21, 1'b1, 4'hD}) begin
      n_fail++;
      $display("FAIL load_digit1: got seg=%h dp=%b an=%h, want seg=21 dp=1 an=d", seg, dp, an);
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL load_model: got %h/%b/%h/%b want %h/%b/%h/%b",
                 seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
      if (an === 4'hB) found = 1'b1;
    end
    n_tests++;
    if (!found || {seg, dp} !== {7'h06, 1'b0}) begin
      n_fail++;
      $display("FAIL load_digit2: got seg=%h dp=%b an=%h, want seg=06 dp=0 an=b", seg, dp, an);
    end
  endtask

  task automatic test_blink();
    int blanks = 0;
    load = 1'b1; codes = 16'($urandom()); dp_in = 4'($urandom()); blink_mask = 4'b0010;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      load = 1'b0;
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL blink_model cycle %0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                 i, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
      if (i >= 2 && an === 4'hF) begin
        blanks++;
        n_tests++;
        if ({seg, dp} !== {7'h7F, 1'b1}) begin
          n_fail++;
          $display("FAIL blink_blank_pins: got seg=%h dp=%b, want seg=7f dp=1", seg, dp);
        end
      end
    end
    n_tests++;
    if (blanks != 8) begin
      n_fail++;
      $display("FAIL blink_count: got %0d blank cycles in 64, want 8", blanks);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 4'hF}) begin
        n_fail++;
        $display("FAIL enable_off cycle %0d: got seg=%h dp=%b an=%h, want 7f/1/f", i, seg, dp, an);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL enable_resume cycle %0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                 i, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load       = ($urandom_range(7) == 0);
      codes      = 16'($urandom());
      dp_in      = 4'($urandom());
      blink_mask = 4'($urandom());
      enable     = ($urandom_range(9) != 0);
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        n_fail++;
        $display("FAIL random_model cycle %0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                 i, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
    load = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an === 4'hB) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got an=%h, want an=b within 20 cycles", an);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_inactive: got seg=%h dp=%b an=%h fd=%b, want 7f/1/f/0",
               seg, dp, an, frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({seg, dp, an, frame_done} !== {7'h40, 1'b1, 4'hE, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_digit0 cycle %0d: got seg=%h dp=%b an=%h fd=%b, want 40/1/e/0",
                 i, seg, dp, an, frame_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_done();
    test_load_mid_digit();
    test_blink();
    test_enable();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
